// File: rtl/snake_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// snake_pkg : shared state/direction encodings and helpers for the Snake game
// Rev 1.0
// ----------------------------------------------------------------------------
package snake_pkg;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_RUN   = 3'd1,
    S_APPLE = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int GRID_N         = 15;
  localparam int DEF_WIN_LENGTH = 225;

  // Same axis (bit 1) but opposite sense (bit 0) means a 180-degree turn.
  function automatic logic is_opposite(input logic [1:0] d, input logic [1:0] cur);
    return (d[1] == cur[1]) && (d[0] != cur[0]);
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] floor_v);
    return (a >= floor_v + b) ? (a - b) : floor_v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_game_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// snake_game_ctrl_if : controller <-> datapath/player signal bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface snake_game_ctrl_if;
  logic        Start;
  logic        Btn_Up;
  logic        Btn_Down;
  logic        Btn_Left;
  logic        Btn_Right;
  logic        Collision;
  logic        New_Apple;
  logic [7:0]  Length;
  logic        Apple_Ack;
  logic        q_I;
  logic        q_Run;
  logic        q_Win;
  logic        q_Lose;
  logic        Speed_Clk;
  logic [1:0]  In_Dirn;
  logic        Apple_Req;
  logic [31:0] Period;

  modport master (
    input  Start, Btn_Up, Btn_Down, Btn_Left, Btn_Right,
    input  Collision, New_Apple, Length, Apple_Ack,
    output q_I, q_Run, q_Win, q_Lose, Speed_Clk, In_Dirn, Apple_Req, Period
  );

  modport slave (
    output Start, Btn_Up, Btn_Down, Btn_Left, Btn_Right,
    output Collision, New_Apple, Length, Apple_Ack,
    input  q_I, q_Run, q_Win, q_Lose, Speed_Clk, In_Dirn, Apple_Req, Period
  );
endinterface
`default_nettype wire

// File: rtl/snake_dir_filter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// snake_dir_filter : button priority, reversal reject, pending/committed dir
// Rev 1.0
// ----------------------------------------------------------------------------
module snake_dir_filter
  import snake_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       clr,
  input  logic       en,
  input  logic       commit,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [1:0] dirn
);

  logic [1:0] pending_q, pending_d;
  logic [1:0] dirn_q, dirn_d;
  logic [1:0] press;
  logic       press_vld;

  always_comb begin
    press_vld = btn_up | btn_down | btn_left | btn_right;
    if (btn_up)         press = DIR_UP;
    else if (btn_down)  press = DIR_DOWN;
    else if (btn_left)  press = DIR_LEFT;
    else                press = DIR_RIGHT;

    pending_d = pending_q;
    dirn_d    = commit ? pending_q : dirn_q;
    // Reversal is judged against the committed direction, never the pending one.
    if (en && press_vld && !is_opposite(press, dirn_q))
      pending_d = press;
    if (clr) begin
      pending_d = DIR_UP;
      dirn_d    = DIR_UP;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pending_q <= DIR_UP;
      dirn_q    <= DIR_UP;
    end else begin
      pending_q <= pending_d;
      dirn_q    <= dirn_d;
    end
  end

  assign dirn = dirn_q;

endmodule
`default_nettype wire

// File: rtl/snake_game_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// snake_game_ctrl : Snake game sequencer, move tick generator, apple handshake
// Rev 1.0
// ----------------------------------------------------------------------------
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int MOVE_PERIOD = 25000000,
  parameter int MIN_PERIOD  = 5000000,
  parameter int SPEED_STEP  = 1000000,
  parameter int WIN_LENGTH  = DEF_WIN_LENGTH
) (
  input logic               Clk,
  input logic               Reset,
  snake_game_ctrl_if.master bus
);

  localparam logic [31:0] C_MOVE    = 32'(MOVE_PERIOD);
  localparam logic [31:0] C_MIN     = 32'(MIN_PERIOD);
  localparam logic [31:0] C_STEP    = 32'(SPEED_STEP);
  localparam logic [7:0]  C_WIN_LEN = 8'(WIN_LENGTH);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] period_q, period_d;
  logic        tick_q, tick_d;
  logic        eval_q, eval_d;
  logic        apple_req_q, apple_req_d;
  logic        q_i_q, q_i_d, q_run_q, q_run_d, q_win_q, q_win_d, q_lose_q, q_lose_d;
  logic        dir_clr;
  logic        dir_en;
  logic [1:0]  w_dirn;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    tick_d      = 1'b0;
    eval_d      = tick_q;
    apple_req_d = apple_req_q;
    dir_clr     = 1'b0;

    case (state_q)
      S_INIT: begin
        cnt_d  = '0;
        eval_d = 1'b0;
        if (bus.Start) begin
          state_d  = S_RUN;
          period_d = C_MOVE;
          dir_clr  = 1'b1;
        end
      end
      S_RUN: begin
        // The move result is judged one cycle after the tick; leaving RUN
        // suppresses any tick that would coincide with it.
        if (eval_q && bus.Collision) begin
          state_d = S_LOSE;
          eval_d  = 1'b0;
        end else if (eval_q && (bus.Length >= C_WIN_LEN)) begin
          state_d = S_WIN;
          eval_d  = 1'b0;
        end else if (eval_q && bus.New_Apple) begin
          state_d     = S_APPLE;
          apple_req_d = 1'b1;
          eval_d      = 1'b0;
        end else if (cnt_q == period_q - 32'd1) begin
          tick_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_APPLE: begin
        eval_d = 1'b0;
        if (bus.Apple_Ack) begin
          apple_req_d = 1'b0;
          period_d    = sat_sub(period_q, C_STEP, C_MIN);
          cnt_d       = '0;
          state_d     = S_RUN;
        end
      end
      S_WIN, S_LOSE: begin
        eval_d = 1'b0;
        cnt_d  = '0;
        if (bus.Start) state_d = S_INIT;
      end
      default: state_d = S_INIT;
    endcase

    q_i_d    = (state_d == S_INIT);
    q_run_d  = (state_d == S_RUN) || (state_d == S_APPLE);
    q_win_d  = (state_d == S_WIN);
    q_lose_d = (state_d == S_LOSE);
    dir_en   = (state_q == S_RUN) || (state_q == S_APPLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      period_q    <= C_MOVE;
      tick_q      <= 1'b0;
      eval_q      <= 1'b0;
      apple_req_q <= 1'b0;
      q_i_q       <= 1'b1;
      q_run_q     <= 1'b0;
      q_win_q     <= 1'b0;
      q_lose_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      tick_q      <= tick_d;
      eval_q      <= eval_d;
      apple_req_q <= apple_req_d;
      q_i_q       <= q_i_d;
      q_run_q     <= q_run_d;
      q_win_q     <= q_win_d;
      q_lose_q    <= q_lose_d;
    end
  end

  snake_dir_filter u_dir_filter (
    .Clk       (Clk),
    .Reset     (Reset),
    .clr       (dir_clr),
    .en        (dir_en),
    .commit    (tick_d),
    .btn_up    (bus.Btn_Up),
    .btn_down  (bus.Btn_Down),
    .btn_left  (bus.Btn_Left),
    .btn_right (bus.Btn_Right),
    .dirn      (w_dirn)
  );

  assign bus.q_I       = q_i_q;
  assign bus.q_Run     = q_run_q;
  assign bus.q_Win     = q_win_q;
  assign bus.q_Lose    = q_lose_q;
  assign bus.Speed_Clk = tick_q;
  assign bus.In_Dirn   = w_dirn;
  assign bus.Apple_Req = apple_req_q;
  assign bus.Period    = period_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_snake_game_ctrl : directed self-checking bench for snake_game_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_snake_game_ctrl;
  import snake_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  snake_game_ctrl_if bus ();

  snake_game_ctrl #(
    .MOVE_PERIOD (4),
    .MIN_PERIOD  (2),
    .SPEED_STEP  (1),
    .WIN_LENGTH  (5)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [1:0] dir_sb[$];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return bus.Apple_Req;
      1:       return bus.q_Lose;
      default: return bus.q_Win;
    endcase
  endfunction

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.Speed_Clk !== 1'b1 && n < 40);
    chk("tick_seen", 32'(bus.Speed_Clk), 32'd1);
  endtask

  task automatic wait_sig(input string tag, input int w);
    int n = 0;
    while (sel(w) !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk(tag, 32'(sel(w)), 32'd1);
  endtask

  task automatic pop_dir(input string tag);
    logic [1:0] e;
    e = (dir_sb.size() > 0) ? dir_sb.pop_front() : 2'bxx;
    chk(tag, 32'(bus.In_Dirn), 32'(e));
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r);
    bus.Btn_Up = u; bus.Btn_Down = d; bus.Btn_Left = l; bus.Btn_Right = r;
    step();
    bus.Btn_Up = 0; bus.Btn_Down = 0; bus.Btn_Left = 0; bus.Btn_Right = 0;
  endtask

  task automatic apple_round();
    bus.New_Apple = 1'b1;
    wait_sig("apple_req_set", 0);
    bus.New_Apple = 1'b0;
    bus.Apple_Ack = 1'b1;
    step();
    bus.Apple_Ack = 1'b0;
    chk("apple_req_drop", 32'(bus.Apple_Req), 32'd0);
  endtask

  initial begin
    int n;
    int ticks;

    Reset = 1'b1;
    bus.Start = 0; bus.Btn_Up = 0; bus.Btn_Down = 0; bus.Btn_Left = 0; bus.Btn_Right = 0;
    bus.Collision = 0; bus.New_Apple = 0; bus.Length = 8'd3; bus.Apple_Ack = 0;
    step();
    step();
    chk("rst_q_I", 32'(bus.q_I), 32'd1);
    chk("rst_q_Run", 32'(bus.q_Run), 32'd0);
    chk("rst_q_Win", 32'(bus.q_Win), 32'd0);
    chk("rst_q_Lose", 32'(bus.q_Lose), 32'd0);
    chk("rst_speed", 32'(bus.Speed_Clk), 32'd0);
    chk("rst_req", 32'(bus.Apple_Req), 32'd0);
    chk("rst_period", bus.Period, 32'd4);
    chk("rst_dirn", 32'(bus.In_Dirn), 32'(DIR_UP));
    Reset = 1'b0;

    // Enter RUN, ticks every 4 cycles after entry.
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    chk("run_entry", 32'(bus.q_Run), 32'd1);
    chk("init_left", 32'(bus.q_I), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("tick_cadence", 32'(bus.Speed_Clk), 32'((k % 4) == 0));
      if ((k % 4) == 0) chk("dir_initial", 32'(bus.In_Dirn), 32'(DIR_UP));
    end

    // Direction filter.
    dir_sb.push_back(DIR_UP);
    press(0, 1, 0, 0);
    wait_tick(n);
    pop_dir("down_rejected");

    dir_sb.push_back(DIR_RIGHT);
    press(0, 0, 1, 0);
    step();
    press(0, 0, 0, 1);
    wait_tick(n);
    pop_dir("left_then_right");

    dir_sb.push_back(DIR_RIGHT);
    press(0, 0, 1, 0);
    wait_tick(n);
    pop_dir("left_rejected");

    dir_sb.push_back(DIR_UP);
    press(1, 1, 0, 0);
    wait_tick(n);
    pop_dir("up_over_down");

    // First apple: request held, ticks frozen until ack.
    bus.New_Apple = 1'b1;
    wait_sig("apple_req_set", 0);
    bus.New_Apple = 1'b0;
    ticks = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.Speed_Clk === 1'b1) ticks++;
    end
    chk("apple_no_tick", 32'(ticks), 32'd0);
    chk("apple_req_hold", 32'(bus.Apple_Req), 32'd1);
    chk("apple_flag_run", 32'(bus.q_Run), 32'd1);
    bus.Apple_Ack = 1'b1;
    step();
    bus.Apple_Ack = 1'b0;
    chk("apple_req_drop", 32'(bus.Apple_Req), 32'd0);
    chk("period_after_1", bus.Period, 32'd3);
    wait_tick(n);
    chk("tick_gap_3", 32'(n), 32'd3);

    apple_round();
    chk("period_after_2", bus.Period, 32'd2);
    wait_tick(n);
    chk("tick_gap_2", 32'(n), 32'd2);

    apple_round();
    chk("period_floor", bus.Period, 32'd2);
    wait_tick(n);

    // Collision outranks apple.
    bus.Collision = 1'b1;
    bus.New_Apple = 1'b1;
    wait_sig("lose", 1);
    chk("lose_no_req", 32'(bus.Apple_Req), 32'd0);
    chk("lose_not_run", 32'(bus.q_Run), 32'd0);
    bus.Collision = 1'b0;
    bus.New_Apple = 1'b0;
    ticks = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.Speed_Clk === 1'b1) ticks++;
    end
    chk("lose_no_tick", 32'(ticks), 32'd0);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    chk("lose_to_init", 32'(bus.q_I), 32'd1);
    chk("lose_cleared", 32'(bus.q_Lose), 32'd0);

    // Win by length; buttons and ticks dead afterwards.
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    chk("period_reload", bus.Period, 32'd4);
    wait_tick(n);
    bus.Length = 8'd5;
    wait_sig("win", 2);
    bus.Length = 8'd3;
    ticks = 0;
    for (int k = 0; k < 10; k++) begin
      press(0, 0, 0, 1);
      if (bus.Speed_Clk === 1'b1) ticks++;
    end
    chk("win_no_tick", 32'(ticks), 32'd0);
    chk("win_dir_frozen", 32'(bus.In_Dirn), 32'(DIR_UP));
    chk("win_hold", 32'(bus.q_Win), 32'd1);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    chk("win_to_init", 32'(bus.q_I), 32'd1);

    // Reset in the middle of an apple handshake.
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    wait_tick(n);
    apple_round();
    chk("period_pre_reset", bus.Period, 32'd3);
    wait_tick(n);
    bus.New_Apple = 1'b1;
    wait_sig("apple_req_again", 0);
    bus.New_Apple = 1'b0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("mid_rst_q_I", 32'(bus.q_I), 32'd1);
    chk("mid_rst_q_Run", 32'(bus.q_Run), 32'd0);
    chk("mid_rst_req", 32'(bus.Apple_Req), 32'd0);
    chk("mid_rst_period", bus.Period, 32'd4);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
